opl3_reg_write_arbiter: RTL and testbench

- Shares the OPL3 register file's single write port between two requesters, e.g. the host-register bridge (requester 0) and a playback/sequencer engine (requester 1).
- Round-robin arbitration.
- Sequences each accepted write as an address phase, then a one-cycle write strobe, then a recovery gap, mirroring real OPL3 bus timing.
- Sits between the requesters and the register file's cs/wr/bank_select/address/data_in inputs in the opl3 top level.

---
 rtl/opl3_pkg.sv | 30 +++
 rtl/opl3_rr_arb2.sv | 23 ++
 rtl/opl3_reg_write_arbiter.sv | 131 +++++++++++++
 tb/tb_opl3_reg_write_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared OPL3 register-file types and widths used by the write-port arbiter.
package opl3_pkg;

    localparam int REG_FILE_ADDRESS_WIDTH   = 8;
    localparam int REG_FILE_DATA_WIDTH      = 8;
    localparam int NUM_REG_WRITE_REQUESTERS = 2;

    // One register-file write as presented by a requester.
    typedef struct packed {
        logic                              bank;
        logic [REG_FILE_ADDRESS_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0]    data;
    } reg_write_t;

    // Bus phases of a single register-file write.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } reg_wr_state_t;

    // Down-counter width covering both the setup range (up to 15) and the recovery gap.
    function automatic int unsigned phase_cnt_width(input int unsigned recovery_cycles);
        int unsigned max_count;
        max_count = (recovery_cycles > 15) ? recovery_cycles : 15;
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/opl3_rr_arb2.sv
// Combinational two-way round-robin grant: the requester that was not served last
// wins when both ask; nothing is granted while enable is low.
module opl3_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // One-hot grant, favouring the requester other than last_grant under contention.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/opl3_reg_write_arbiter.sv
// Shares the OPL3 register file's single write port between two requesters.
// Each accepted write is played out as address setup, a one-cycle write strobe
// and a recovery gap, matching real OPL3 bus timing.
module opl3_reg_write_arbiter
    import opl3_pkg::*;
#(
    parameter int unsigned ADDR_SETUP_CYCLES     = 1,
    parameter int unsigned WRITE_RECOVERY_CYCLES = 32
) (
    input  logic                                                           clk,
    input  logic                                                           reset_n,
    input  logic                                                           enable,
    input  logic [NUM_REG_WRITE_REQUESTERS-1:0]                            req_valid,
    output logic [NUM_REG_WRITE_REQUESTERS-1:0]                            req_ready,
    input  logic [NUM_REG_WRITE_REQUESTERS-1:0]                            req_bank,
    input  logic [NUM_REG_WRITE_REQUESTERS-1:0][REG_FILE_ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REG_WRITE_REQUESTERS-1:0][REG_FILE_DATA_WIDTH-1:0]    req_data,
    output logic                                                           cs,
    output logic                                                           wr,
    output logic                                                           bank_select,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0]                              address,
    output logic [REG_FILE_DATA_WIDTH-1:0]                                 data_in,
    output logic                                                           busy,
    output logic                                                           last_grant
);

    localparam int unsigned CNT_W = phase_cnt_width(WRITE_RECOVERY_CYCLES);

    // Counter reload values; the counter expires at zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(ADDR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD =
        CNT_W'((WRITE_RECOVERY_CYCLES > 0) ? (WRITE_RECOVERY_CYCLES - 1) : 0);

    reg_wr_state_t                  state;
    logic [CNT_W-1:0]               cnt;
    logic [REG_FILE_DATA_WIDTH-1:0] hold_data;
    logic [1:0]                     grant;
    logic                           arb_enable;
    logic                           xfer;
    reg_write_t                     pick;

    // Grants are only offered from IDLE, and never while reset is asserted.
    assign arb_enable = enable & reset_n & (state == IDLE);

    opl3_rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_enable),
        .grant      (grant)
    );

    // The arbiter only grants a requester whose valid is high, so any grant is a transfer.
    assign req_ready = grant;
    assign xfer      = |grant;
    assign busy      = (state != IDLE);

    // Select the payload of whichever requester is being granted this cycle.
    always_comb begin
        pick = '0;
        if (grant[1]) begin
            pick.bank    = req_bank[1];
            pick.address = req_address[1];
            pick.data    = req_data[1];
        end else begin
            pick.bank    = req_bank[0];
            pick.address = req_address[0];
            pick.data    = req_data[0];
        end
    end

    // Write sequencer: IDLE -> ADDR (setup) -> STROBE (1 cycle) -> RECOVER (gap) -> IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_data   <= '0;
            last_grant  <= 1'b1;
            cs          <= 1'b0;
            wr          <= 1'b0;
            bank_select <= 1'b0;
            address     <= '0;
            data_in     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state       <= ADDR;
                        cnt         <= SETUP_LOAD;
                        hold_data   <= pick.data;
                        bank_select <= pick.bank;
                        address     <= pick.address;
                        last_grant  <= grant[1];
                        cs          <= 1'b1;
                        wr          <= 1'b0;
                    end
                end
                ADDR: begin
                    if (cnt == '0) begin
                        // data_in is only refreshed as the strobe begins
                        state   <= STROBE;
                        wr      <= 1'b1;
                        data_in <= hold_data;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    cs <= 1'b0;
                    wr <= 1'b0;
                    if (WRITE_RECOVERY_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        state <= RECOVER;
                        cnt   <= RECOVER_LOAD;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opl3_reg_write_arbiter.sv
// Bench for opl3_reg_write_arbiter: two instances (default timing, and 3-cycle setup
// with no recovery) share one set of stimulus and are checked every cycle against a
// time-since-grant model, plus directed scenarios with literal expectations.
module tb_opl3_reg_write_arbiter;
    import opl3_pkg::*;

    localparam int AW = REG_FILE_ADDRESS_WIDTH;
    localparam int DW = REG_FILE_DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  enable = 1'b1;
    logic [1:0]            req_valid = 2'b00;
    logic [1:0]            req_bank = 2'b00;
    logic [1:0][AW-1:0]    req_address = '0;
    logic [1:0][DW-1:0]    req_data = '0;

    logic [1:0]    ready_o [2];
    logic          cs_o    [2];
    logic          wr_o    [2];
    logic          bank_o  [2];
    logic          busy_o  [2];
    logic          lg_o    [2];
    logic [AW-1:0] addr_o  [2];
    logic [DW-1:0] din_o   [2];

    always #5 clk = ~clk;

    opl3_reg_write_arbiter #(.ADDR_SETUP_CYCLES(1), .WRITE_RECOVERY_CYCLES(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_ready(ready_o[0]), .req_bank(req_bank),
        .req_address(req_address), .req_data(req_data),
        .cs(cs_o[0]), .wr(wr_o[0]), .bank_select(bank_o[0]), .address(addr_o[0]),
        .data_in(din_o[0]), .busy(busy_o[0]), .last_grant(lg_o[0])
    );

    opl3_reg_write_arbiter #(.ADDR_SETUP_CYCLES(3), .WRITE_RECOVERY_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_ready(ready_o[1]), .req_bank(req_bank),
        .req_address(req_address), .req_data(req_data),
        .cs(cs_o[1]), .wr(wr_o[1]), .bank_select(bank_o[1]), .address(addr_o[1]),
        .data_in(din_o[1]), .busy(busy_o[1]), .last_grant(lg_o[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t counts cycles since the transfer edge (0 = idle). For a write with setup S
    // and recovery R: cs during t=1..S+1, wr at t=S+1, busy for t=1..S+1+R.
    int            m_t    [2];
    logic          m_last [2];
    logic          m_bank [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_hold [2];
    logic [DW-1:0] m_din  [2];

    function automatic int setup_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int recov_of(input int i);
        return (i == 0) ? 32 : 0;
    endfunction

    // Who may go: a lone requester, or under contention the one not served last.
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    logic [DW-1:0] wr_log_a [$];
    int            wr_cyc_a [$];
    int            wr_cyc_b [$];
    int            wr_cnt_a = 0;
    logic [AW-1:0] hist_b [3];

    logic [1:0] e_rdy;
    int         s_c, r_c;
    logic       g;

    // Compare process: checks every output of both instances each cycle, then advances the model.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            s_c = setup_of(i);
            r_c = recov_of(i);
            if (!reset_n) begin
                m_t[i] = 0; m_last[i] = 1'b1; m_bank[i] = 1'b0;
                m_addr[i] = '0; m_hold[i] = '0; m_din[i] = '0;
            end
            e_rdy = (reset_n && enable && m_t[i] == 0) ? rr_pick(req_valid, m_last[i]) : 2'b00;
            check("req_ready", i, ready_o[i], e_rdy);
            check("cs", i, cs_o[i], (m_t[i] >= 1 && m_t[i] <= s_c + 1));
            check("wr", i, wr_o[i], (m_t[i] == s_c + 1));
            check("busy", i, busy_o[i], (m_t[i] != 0));
            check("last_grant", i, lg_o[i], m_last[i]);
            check("bank_select", i, bank_o[i], m_bank[i]);
            check("address", i, addr_o[i], m_addr[i]);
            check("data_in", i, din_o[i], m_din[i]);
            if (reset_n) begin
                if (m_t[i] == 0) begin
                    if (e_rdy != 2'b00) begin
                        g         = e_rdy[1];
                        m_last[i] = g;
                        m_bank[i] = req_bank[g];
                        m_addr[i] = req_address[g];
                        m_hold[i] = req_data[g];
                        m_t[i]    = 1;
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == s_c + 1) m_din[i] = m_hold[i];
                    if (m_t[i] > s_c + 1 + r_c) m_t[i] = 0;
                end
            end
        end
        if (wr_o[0] === 1'b1) begin
            wr_log_a.push_back(din_o[0]);
            wr_cyc_a.push_back(cyc);
            wr_cnt_a++;
        end
        if (wr_o[1] === 1'b1) begin
            wr_cyc_b.push_back(cyc);
            for (int k = 0; k < 3; k++) check("b_addr_stable", 1, hist_b[k], addr_o[1]);
        end
        hist_b[2] = hist_b[1];
        hist_b[1] = hist_b[0];
        hist_b[0] = addr_o[1];
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 100; k++) begin
            if (!busy_o[0] && !busy_o[1]) break;
            next();
        end
        check(tag, 0, {busy_o[0], busy_o[1]}, 2'b00);
    endtask

    int n0, n1, base;

    initial begin
        // Reset state, with requests pending to show ready stays low in reset
        #2;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        next(); next(); next();
        #3;
        for (int i = 0; i < 2; i++) begin
            check("rst_cs", i, cs_o[i], 1'b0);
            check("rst_wr", i, wr_o[i], 1'b0);
            check("rst_busy", i, busy_o[i], 1'b0);
            check("rst_ready", i, ready_o[i], 2'b00);
            check("rst_last_grant", i, lg_o[i], 1'b1);
            check("rst_address", i, addr_o[i], 8'h00);
        end
        next();
        reset_n   = 1'b1;
        req_valid = 2'b00;
        next();

        // Single write from requester 0 with default timing
        req_valid      = 2'b01;
        req_bank[0]    = 1'b1;
        req_address[0] = 8'hB0;
        req_data[0]    = 8'h31;
        #3;
        check("t2_ready_c0", 0, ready_o[0], 2'b01);
        next();
        req_valid = 2'b00;
        for (int c = 1; c <= 35; c++) begin
            if (c == 34) req_valid = 2'b01;
            #3;
            if (c == 1) begin
                check("t2_cs_c1", 0, cs_o[0], 1'b1);
                check("t2_wr_c1", 0, wr_o[0], 1'b0);
                check("t2_addr_c1", 0, addr_o[0], 8'hB0);
            end
            if (c == 2) begin
                check("t2_cs_c2", 0, cs_o[0], 1'b1);
                check("t2_wr_c2", 0, wr_o[0], 1'b1);
                check("t2_din_c2", 0, din_o[0], 8'h31);
                check("t2_bank_c2", 0, bank_o[0], 1'b1);
            end
            if (c == 3) check("t2_wr_c3", 0, wr_o[0], 1'b0);
            if (c == 34) begin
                check("t2_busy_c34", 0, busy_o[0], 1'b1);
                check("t2_ready_c34", 0, ready_o[0], 2'b00);
            end
            if (c == 35) begin
                check("t2_busy_c35", 0, busy_o[0], 1'b0);
                check("t2_ready_c35", 0, ready_o[0], 2'b01);
            end
            next();
        end

        // Asynchronous reset while dut_a is in its address phase
        check("t3_cs_before", 0, cs_o[0], 1'b1);
        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("t3_cs_async", i, cs_o[i], 1'b0);
            check("t3_wr_async", i, wr_o[i], 1'b0);
            check("t3_busy_async", i, busy_o[i], 1'b0);
            check("t3_ready_async", i, ready_o[i], 2'b00);
        end
        next(); next();
        reset_n = 1'b1;

        // Continuous contention on dut_a: four writes per requester, alternating
        wr_log_a.delete();
        wr_cyc_a.delete();
        n0 = 0; n1 = 0;
        req_bank = 2'b10;
        for (int c = 0; c < 400 && (n0 < 4 || n1 < 4); c++) begin
            req_valid      = {(n1 < 4), (n0 < 4)};
            req_data[0]    = DW'(8'hA0 + n0);
            req_data[1]    = DW'(8'hB0 + n1);
            req_address[0] = AW'(8'h20 + n0);
            req_address[1] = AW'(8'h40 + n1);
            #3;
            if (c == 0) check("t4_first_grant", 0, ready_o[0], 2'b01);
            if (req_valid[0] && ready_o[0][0]) n0++;
            if (req_valid[1] && ready_o[0][1]) n1++;
            next();
        end
        req_valid = 2'b00;
        for (int k = 0; k < 60 && wr_log_a.size() < 8; k++) next();
        check("t4_wr_count", 0, wr_log_a.size(), 8);
        for (int k = 0; k < 8 && k < wr_log_a.size(); k++)
            check("t4_order", k, wr_log_a[k], (k % 2 == 0) ? (32'hA0 + k / 2) : (32'hB0 + k / 2));
        for (int k = 1; k < 8 && k < wr_cyc_a.size(); k++)
            check("t4_spacing", k, wr_cyc_a[k] - wr_cyc_a[k-1], 35);

        // Requester 1 streaming into dut_b (3-cycle setup, no recovery)
        wait_idle("t5_idle");
        wr_cyc_b.delete();
        n1 = 0;
        for (int c = 0; c < 60 && n1 < 3; c++) begin
            req_valid      = 2'b10;
            req_data[1]    = DW'(8'hC0 + n1);
            req_address[1] = AW'(8'h60 + n1);
            req_bank[1]    = n1[0];
            #3;
            if (ready_o[1][1]) n1++;
            next();
        end
        req_valid = 2'b00;
        for (int k = 0; k < 20 && wr_cyc_b.size() < 3; k++) next();
        check("t5_wr_count", 1, wr_cyc_b.size(), 3);
        for (int k = 1; k < 3 && k < wr_cyc_b.size(); k++)
            check("t5_spacing", k, wr_cyc_b[k] - wr_cyc_b[k-1], 5);

        // enable dropped during the strobe of a dut_a write
        wait_idle("t6_idle");
        enable         = 1'b1;
        req_valid      = 2'b01;
        req_address[0] = 8'h55;
        req_data[0]    = 8'h5A;
        #3;
        check("t6_ready0", 0, ready_o[0], 2'b01);
        next();
        req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            #3;
            if (wr_o[0]) break;
            next();
        end
        check("t6_strobe_seen", 0, wr_o[0], 1'b1);
        enable = 1'b0;
        next();
        for (int k = 0; k < 40; k++) begin
            #3;
            check("t6_no_ready", 0, ready_o[0], 2'b00);
            next();
        end
        check("t6_done_busy", 0, busy_o[0], 1'b0);
        enable = 1'b1;
        #3;
        check("t6_regrant", 0, ready_o[0], 2'b10);
        next();
        req_valid = 2'b00;

        // Requester 1 withdraws while dut_a is busy
        wait_idle("t7_idle");
        base           = wr_cnt_a;
        req_valid      = 2'b01;
        req_address[0] = 8'h10;
        req_data[0]    = 8'h77;
        #3;
        check("t7_ready0", 0, ready_o[0], 2'b01);
        next();
        for (int c = 1; c <= 8; c++) begin
            req_valid = (c == 5 || c == 6) ? 2'b10 : 2'b00;
            #3;
            check("t7_no_ready", 0, ready_o[0], 2'b00);
            next();
        end
        req_valid = 2'b00;
        wait_idle("t7_idle_end");
        next(); next();
        check("t7_wr_pulses", 0, wr_cnt_a - base, 1);
        check("t7_last_grant", 0, lg_o[0], 1'b0);

        // Randomized traffic, enable toggling and occasional mid-cycle resets
        for (int c = 0; c < 2000; c++) begin
            req_valid      = 2'($urandom_range(0, 3));
            enable         = ($urandom_range(0, 9) != 0);
            req_bank       = 2'($urandom);
            req_address[0] = AW'($urandom);
            req_address[1] = AW'($urandom);
            req_data[0]    = DW'($urandom);
            req_data[1]    = DW'($urandom);
            if ($urandom_range(0, 399) == 0) #1 reset_n = 1'b0;
            next();
            reset_n = 1'b1;
        end
        req_valid = 2'b00;
        enable    = 1'b1;
        next(); next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
